// File: rtl/mem_access.sv
// Memory-access stage: passes ALU results through, or performs one aligned
// byte/half/word load or store over a req/ack data port, with timeout abort.
module mem_access #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Valid,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic [4:0]  RAddrIn,
  input  logic        RegWriteIn,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic        MemtoRegIn,
  input  logic [1:0]  MemSize,
  input  logic        MemSigned,
  output logic        Stall,
  output logic        DReq,
  output logic        DWe,
  output logic [31:0] DAddr,
  output logic [3:0]  DBe,
  output logic [31:0] DWData,
  input  logic [31:0] DRData,
  input  logic        DAck,
  output logic        WBValid,
  output logic [31:0] WBData,
  output logic [4:0]  WBAddr,
  output logic        RegWriteOut,
  output logic        AlignErr,
  output logic        BusErr
);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_n;
  logic [15:0] cnt_q, cnt_n;

  logic [31:0] lat_addr, lat_addr_n;
  logic [4:0]  lat_raddr, lat_raddr_n;
  logic        lat_rw, lat_rw_n;
  logic        lat_load, lat_load_n;
  logic        lat_m2r, lat_m2r_n;
  logic [1:0]  lat_size, lat_size_n;
  logic        lat_signed, lat_signed_n;

  logic        dreq_n, dwe_n, wbvalid_n, regwr_n, alignerr_n, buserr_n;
  logic [31:0] daddr_n, dwdata_n, wbdata_n;
  logic [3:0]  dbe_n;
  logic [4:0]  wbaddr_n;

  logic        is_mem, misaligned;
  logic [3:0]  be_in;
  logic [31:0] wd_rep, rshift, ld_val;

  assign Stall = (state_q == S_ACCESS);

  // Request-side decode of the incoming op.
  always_comb begin
    is_mem = MemReadIn | MemWriteIn;
    be_in  = 4'b1111;
    wd_rep = WriteData;
    misaligned = 1'b0;
    unique case (MemSize)
      2'b00: begin
        be_in  = 4'b0001 << Address[1:0];
        wd_rep = {4{WriteData[7:0]}};
      end
      2'b01: begin
        be_in  = 4'b0011 << {Address[1], 1'b0};
        wd_rep = {2{WriteData[15:0]}};
        misaligned = Address[0];
      end
      default: misaligned = (Address[1:0] != 2'b00);
    endcase
    misaligned = misaligned & is_mem;
  end

  // Load lane selection: shift the addressed lane down to bit 0, then extend.
  always_comb begin
    rshift = DRData >> {lat_addr[1:0], 3'b000};
    unique case (lat_size)
      2'b00:   ld_val = {{24{lat_signed & rshift[7]}}, rshift[7:0]};
      2'b01:   ld_val = {{16{lat_signed & rshift[15]}}, rshift[15:0]};
      default: ld_val = DRData;
    endcase
  end

  always_comb begin
    state_n      = state_q;
    cnt_n        = cnt_q;
    dreq_n       = DReq;
    dwe_n        = DWe;
    daddr_n      = DAddr;
    dbe_n        = DBe;
    dwdata_n     = DWData;
    wbvalid_n    = 1'b0;
    wbdata_n     = WBData;
    wbaddr_n     = WBAddr;
    regwr_n      = 1'b0;
    alignerr_n   = 1'b0;
    buserr_n     = 1'b0;
    lat_addr_n   = lat_addr;
    lat_raddr_n  = lat_raddr;
    lat_rw_n     = lat_rw;
    lat_load_n   = lat_load;
    lat_m2r_n    = lat_m2r;
    lat_size_n   = lat_size;
    lat_signed_n = lat_signed;

    unique case (state_q)
      S_IDLE: begin
        if (Valid) begin
          if (!is_mem || misaligned) begin
            wbvalid_n  = 1'b1;
            wbdata_n   = Address;
            wbaddr_n   = RAddrIn;
            regwr_n    = RegWriteIn & ~misaligned;
            alignerr_n = misaligned;
          end else begin
            state_n      = S_ACCESS;
            cnt_n        = '0;
            dreq_n       = 1'b1;
            dwe_n        = MemWriteIn;
            daddr_n      = {Address[31:2], 2'b00};
            dbe_n        = be_in;
            dwdata_n     = wd_rep;
            lat_addr_n   = Address;
            lat_raddr_n  = RAddrIn;
            lat_rw_n     = RegWriteIn;
            lat_load_n   = MemReadIn & ~MemWriteIn;
            lat_m2r_n    = MemtoRegIn;
            lat_size_n   = MemSize;
            lat_signed_n = MemSigned;
          end
        end
      end
      S_ACCESS: begin
        if (DAck) begin
          state_n   = S_IDLE;
          dreq_n    = 1'b0;
          wbvalid_n = 1'b1;
          wbaddr_n  = lat_raddr;
          regwr_n   = lat_rw;
          wbdata_n  = (lat_load && lat_m2r) ? ld_val : lat_addr;
        end else if (cnt_q == CNT_LAST) begin
          state_n   = S_IDLE;
          dreq_n    = 1'b0;
          wbvalid_n = 1'b1;
          wbaddr_n  = lat_raddr;
          wbdata_n  = lat_addr;
          buserr_n  = 1'b1;
        end else begin
          cnt_n = cnt_q + 16'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      DReq        <= '0;
      DWe         <= '0;
      DAddr       <= '0;
      DBe         <= '0;
      DWData      <= '0;
      WBValid     <= '0;
      WBData      <= '0;
      WBAddr      <= '0;
      RegWriteOut <= '0;
      AlignErr    <= '0;
      BusErr      <= '0;
      lat_addr    <= '0;
      lat_raddr   <= '0;
      lat_rw      <= '0;
      lat_load    <= '0;
      lat_m2r     <= '0;
      lat_size    <= '0;
      lat_signed  <= '0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      DReq        <= dreq_n;
      DWe         <= dwe_n;
      DAddr       <= daddr_n;
      DBe         <= dbe_n;
      DWData      <= dwdata_n;
      WBValid     <= wbvalid_n;
      WBData      <= wbdata_n;
      WBAddr      <= wbaddr_n;
      RegWriteOut <= regwr_n;
      AlignErr    <= alignerr_n;
      BusErr      <= buserr_n;
      lat_addr    <= lat_addr_n;
      lat_raddr   <= lat_raddr_n;
      lat_rw      <= lat_rw_n;
      lat_load    <= lat_load_n;
      lat_m2r     <= lat_m2r_n;
      lat_size    <= lat_size_n;
      lat_signed  <= lat_signed_n;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: random ops, reference model, bus responder.
module tb_mem_access;

  localparam int unsigned TO = 4;

  logic        Clock = 1'b0;
  logic        Reset, Valid;
  logic [31:0] Address, WriteData;
  logic [4:0]  RAddrIn;
  logic        RegWriteIn, MemReadIn, MemWriteIn, MemtoRegIn;
  logic [1:0]  MemSize;
  logic        MemSigned;
  logic        Stall, DReq, DWe;
  logic [31:0] DAddr, DWData, DRData;
  logic [3:0]  DBe;
  logic        DAck;
  logic        WBValid;
  logic [31:0] WBData;
  logic [4:0]  WBAddr;
  logic        RegWriteOut, AlignErr, BusErr;

  mem_access #(.TIMEOUT(TO)) dut (
    .Clock(Clock), .Reset(Reset), .Valid(Valid), .Address(Address),
    .WriteData(WriteData), .RAddrIn(RAddrIn), .RegWriteIn(RegWriteIn),
    .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn), .MemtoRegIn(MemtoRegIn),
    .MemSize(MemSize), .MemSigned(MemSigned), .Stall(Stall), .DReq(DReq),
    .DWe(DWe), .DAddr(DAddr), .DBe(DBe), .DWData(DWData), .DRData(DRData),
    .DAck(DAck), .WBValid(WBValid), .WBData(WBData), .WBAddr(WBAddr),
    .RegWriteOut(RegWriteOut), .AlignErr(AlignErr), .BusErr(BusErr)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  waddr;
    logic        rw, aerr, berr, chkdata, chkaddr;
    int unsigned nreq;
  } res_t;
  typedef struct {
    logic [31:0] addr, wdata;
    logic        we;
    logic [3:0]  be;
  } bus_t;
  typedef struct {
    int unsigned k;
    logic [31:0] rdata;
  } resp_t;

  res_t  resq[$];
  bus_t  busq[$];
  resp_t respq[$];

  int vectors = 0;
  int miscompares = 0;
  logic ack_force = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  function automatic int unsigned nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] load_model(input logic [31:0] a, input logic [31:0] rd,
                                             input logic [1:0] sz, input logic sgn);
    int unsigned nb = nbytes(sz);
    logic [63:0] mask = (64'd1 << (8 * nb)) - 64'd1;
    logic [63:0] v = (64'(rd) >> (8 * int'(a[1:0]))) & mask;
    if (sgn && ((v >> (8 * nb - 1)) & 64'd1) != 64'd0) v = v | ~mask;
    return v[31:0];
  endfunction

  function automatic bus_t bus_model(input logic [31:0] a, input logic [31:0] wd,
                                     input logic wr, input logic [1:0] sz);
    bus_t b;
    int unsigned nb = nbytes(sz);
    int unsigned off = int'(a[1:0]);
    b.addr = a & 32'hFFFF_FFFC;
    b.we   = wr;
    b.be   = 4'(((1 << nb) - 1) << off);
    for (int unsigned i = 0; i < 4; i++) b.wdata[8*i +: 8] = wd[8*(i % nb) +: 8];
    return b;
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rdst,
                       input logic rw, input logic rd, input logic wr, input logic m2r,
                       input logic [1:0] sz, input logic sgn, input int unsigned k,
                       input logic [31:0] rdata, input bit track);
    res_t r;
    bit   is_mem, mis;
    int   g = 0;
    while (Stall === 1'b1 && g < 100) begin
      Valid = 1'($urandom_range(0, 1));
      Address = $urandom; MemReadIn = 1'($urandom_range(0, 1));
      MemWriteIn = 1'($urandom_range(0, 1)); RAddrIn = 5'($urandom);
      @(posedge Clock); #1;
      g++;
    end
    if (g >= 100) bound_fail("stall_release");
    is_mem = rd | wr;
    mis    = is_mem && (a % nbytes(sz) != 0);
    r = '{data: a, waddr: rdst, rw: rw, aerr: 1'b0, berr: 1'b0,
          chkdata: 1'b1, chkaddr: 1'b1, nreq: 0};
    if (mis) begin
      r.aerr = 1'b1; r.rw = 1'b0; r.chkdata = 1'b0; r.chkaddr = 1'b0;
    end else if (is_mem) begin
      busq.push_back(bus_model(a, wd, wr, sz));
      respq.push_back('{k: k, rdata: rdata});
      if (k > TO) begin
        r.berr = 1'b1; r.rw = 1'b0; r.nreq = TO; r.chkdata = 1'b0; r.chkaddr = 1'b0;
      end else begin
        r.nreq = k;
        if (rd && !wr && m2r) r.data = load_model(a, rdata, sz, sgn);
      end
    end
    if (track) resq.push_back(r);
    Valid = 1'b1; Address = a; WriteData = wd; RAddrIn = rdst; RegWriteIn = rw;
    MemReadIn = rd; MemWriteIn = wr; MemtoRegIn = m2r; MemSize = sz; MemSigned = sgn;
    @(posedge Clock); #1;
    Valid = 1'b0;
  endtask

  // Memory responder: acks the k-th request cycle of each transaction.
  initial begin
    bit          active = 1'b0;
    int unsigned cyc = 0;
    resp_t       cur = '{k: 0, rdata: '0};
    DAck = 1'b0; DRData = '0;
    forever begin
      @(posedge Clock); #1;
      if (DReq === 1'b1) begin
        if (!active) begin
          active = 1'b1; cyc = 1;
          if (respq.size() != 0) cur = respq.pop_front();
          else cur = '{k: 0, rdata: '0};
        end else cyc++;
        DAck   = (cyc == cur.k);
        DRData = DAck ? cur.rdata : $urandom;
      end else begin
        active = 1'b0;
        DAck   = ack_force | 1'($urandom_range(0, 1));
        DRData = $urandom;
      end
    end
  end

  // Monitor: checks bus requests and writeback results against the queues.
  initial begin
    bit          prev_dreq = 1'b0;
    int unsigned reqcnt = 0, stallcnt = 0;
    bus_t        cb = '{addr: '0, wdata: '0, we: 1'b0, be: '0};
    res_t        r;
    forever begin
      @(negedge Clock);
      if (Reset !== 1'b0) begin
        prev_dreq = 1'b0; reqcnt = 0; stallcnt = 0;
      end else begin
        if (DReq === 1'b1) begin
          if (!prev_dreq) begin
            if (busq.size() == 0) begin
              chk("unexpected_dreq", 32'(DReq), 32'd0);
            end else begin
              cb = busq.pop_front();
              chk("daddr", DAddr, cb.addr);
              chk("dwe", 32'(DWe), 32'(cb.we));
              chk("dbe", 32'(DBe), 32'(cb.be));
              if (cb.we) chk("dwdata", DWData, cb.wdata);
            end
          end else begin
            chk("daddr_stable", DAddr, cb.addr);
            chk("dbe_stable", 32'(DBe), 32'(cb.be));
          end
          reqcnt++;
        end
        prev_dreq = (DReq === 1'b1);
        if (Stall === 1'b1) stallcnt++;
        if (WBValid === 1'b1) begin
          if (resq.size() == 0) begin
            chk("unexpected_wbvalid", 32'(WBValid), 32'd0);
          end else begin
            r = resq.pop_front();
            chk("alignerr", 32'(AlignErr), 32'(r.aerr));
            chk("buserr", 32'(BusErr), 32'(r.berr));
            chk("regwrite", 32'(RegWriteOut), 32'(r.rw));
            chk("dreq_cycles", reqcnt, r.nreq);
            chk("stall_cycles", stallcnt, r.nreq);
            if (r.chkaddr) chk("wbaddr", 32'(WBAddr), 32'(r.waddr));
            if (r.chkdata) chk("wbdata", WBData, r.data);
          end
          reqcnt = 0; stallcnt = 0;
        end
      end
    end
  end

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_dreq"}, 32'(DReq), 0);
    chk({pfx, "_dwe"}, 32'(DWe), 0);
    chk({pfx, "_daddr"}, DAddr, 0);
    chk({pfx, "_dbe"}, 32'(DBe), 0);
    chk({pfx, "_dwdata"}, DWData, 0);
    chk({pfx, "_wbvalid"}, 32'(WBValid), 0);
    chk({pfx, "_wbdata"}, WBData, 0);
    chk({pfx, "_wbaddr"}, 32'(WBAddr), 0);
    chk({pfx, "_regwrite"}, 32'(RegWriteOut), 0);
    chk({pfx, "_alignerr"}, 32'(AlignErr), 0);
    chk({pfx, "_buserr"}, 32'(BusErr), 0);
    chk({pfx, "_stall"}, 32'(Stall), 0);
  endtask

  task automatic drain();
    int g = 0;
    while ((resq.size() != 0 || Stall === 1'b1) && g < 200) begin
      @(posedge Clock); #1;
      g++;
    end
    if (g >= 200) bound_fail("drain");
  endtask

  initial begin
    logic [31:0] a;
    int unsigned kind;
    Reset = 1'b1; Valid = 1'b0; Address = '0; WriteData = '0; RAddrIn = '0;
    RegWriteIn = 1'b0; MemReadIn = 1'b0; MemWriteIn = 1'b0; MemtoRegIn = 1'b0;
    MemSize = '0; MemSigned = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    chk_all_zero("reset");
    Reset = 1'b0;
    @(posedge Clock); #1;

    // Directed cases from the plan.
    issue(32'h1234, 32'hDEAD_BEEF, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1, '0, 1'b1);
    issue(32'h103, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 3, 32'h80FF_FFFF, 1'b1);
    issue(32'h202, 32'hAABB_CCDD, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 2, '0, 1'b1);
    issue(32'h6, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 1, '0, 1'b1);
    issue(32'h400, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 9, 32'h1111_2222, 1'b1);
    issue(32'h502, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1, 32'h8001_7FFF, 1'b1);
    drain();

    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 3);
      a = $urandom;
      if ($urandom_range(0, 1) != 0) a[1:0] = 2'b00;
      issue(a, $urandom, 5'($urandom), 1'($urandom_range(0, 1)),
            (kind == 1 || kind == 3), (kind >= 2), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom_range(1, 6), $urandom, 1'b1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge Clock); #1;
      end
    end
    drain();

    // Reset in the second ACCESS cycle abandons the transaction.
    issue(32'h300, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 50, '0, 1'b0);
    chk("rst_pre_dreq", 32'(DReq), 32'd1);
    @(posedge Clock); #1;
    chk("rst_pre_dreq2", 32'(DReq), 32'd1);
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    chk_all_zero("rst_mid");
    ack_force = 1'b1;
    repeat (5) begin
      @(posedge Clock); #1;
      chk("rst_post_wbvalid", 32'(WBValid), 32'd0);
      chk("rst_post_dreq", 32'(DReq), 32'd0);
    end
    ack_force = 1'b0;
    issue(32'h1234, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1, '0, 1'b1);
    drain();
    @(posedge Clock); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
